hex_display_ctrl: RTL and testbench

//  Converts a binary value into per-digit control fields (NUM/DEC/SIGN/OFF) for

---
 rtl/hex_display_ctrl_if.sv | 28 ++
 rtl/hex_display_ctrl.sv | 145 ++++++++++++++
 tb/tb_hex_display_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_ctrl_if.sv
// Load request plus per-digit display fields between a datapath and hex_display_ctrl.
interface hex_display_ctrl_if #(
    parameter int DIGITS = 6,
    parameter int WIDTH  = 16
);
    logic                  load;
    logic [WIDTH-1:0]      value;
    logic                  signed_mode;
    logic                  hex_mode;
    logic [DIGITS-1:0]     dp_sel;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [4*DIGITS-1:0]   dig_num;
    logic [DIGITS-1:0]     dig_dec;
    logic [DIGITS-1:0]     dig_sign;
    logic [DIGITS-1:0]     dig_off;

    modport master (
        output load, value, signed_mode, hex_mode, dp_sel,
        input  busy, done, ovf, dig_num, dig_dec, dig_sign, dig_off
    );

    modport slave (
        input  load, value, signed_mode, hex_mode, dp_sel,
        output busy, done, ovf, dig_num, dig_dec, dig_sign, dig_off
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// Binary -> per-digit NUM/DEC/SIGN/OFF fields; decimal by one-bit-per-cycle double-dabble or raw hex.
// DONE two edges after acceptance (hex) or WIDTH+2 edges (decimal); LOAD ignored while a conversion is pending.
module hex_display_ctrl #(
    parameter int DIGITS = 6,
    parameter int WIDTH  = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    hex_display_ctrl_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int XW = (WIDTH > BW) ? WIDTH : BW;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONV, FINAL} state_t;
    state_t state, state_nxt;

    logic              start;
    logic              hex_q;
    logic              neg;
    logic              ovf_acc;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  mag;
    logic [BW-1:0]     bcd;
    logic [DIGITS-1:0] dp;

    logic [BW-1:0]     num_q;
    logic [DIGITS-1:0] dec_q, sign_q, off_q;
    logic              ovf_q, done_q;

    logic              accept;
    logic [XW-1:0]     value_ext;
    logic [WIDTH-1:0]  mag_in;
    logic [BW-1:0]     bcd_adj;

    logic [BW-1:0]     f_num;
    logic [DIGITS-1:0] f_dec, f_sign, f_off;
    logic              f_ovf;
    int                top;

    // A start flag separates acceptance from the first FSM step, so BUSY rises one edge after LOAD.
    assign accept    = (state == IDLE) && !start && bus.load;
    assign value_ext = XW'(bus.value);
    assign mag_in    = (bus.signed_mode && bus.value[WIDTH-1]) ? (~bus.value + 1'b1) : bus.value;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = hex_q ? FINAL : CONV;
            CONV:    if (cnt == CW'(WIDTH - 1)) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Highest shown digit is the highest nonzero digit or the highest decimal point, whichever is further left.
    always_comb begin
        top = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((bcd[4*i +: 4] != 4'd0) || dp[i]) top = i;
        end
        f_ovf  = ovf_acc | (neg & (top == DIGITS - 1));
        f_num  = '0;
        f_dec  = '0;
        f_sign = '0;
        f_off  = '0;
        if (f_ovf) begin
            f_sign = '1;
        end else begin
            f_dec = dp;
            for (int i = 0; i < DIGITS; i++) begin
                if (i <= top)                    f_num[4*i +: 4] = bcd[4*i +: 4];
                else if (neg && (i == top + 1))  f_sign[i] = 1'b1;
                else                             f_off[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start   <= 1'b0;
            hex_q   <= 1'b0;
            neg     <= 1'b0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
            mag     <= '0;
            bcd     <= '0;
            dp      <= '0;
            num_q   <= '0;
            dec_q   <= '0;
            sign_q  <= '0;
            off_q   <= '1;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                start   <= 1'b1;
                hex_q   <= bus.hex_mode;
                neg     <= !bus.hex_mode && bus.signed_mode && bus.value[WIDTH-1];
                mag     <= mag_in;
                dp      <= bus.dp_sel;
                cnt     <= '0;
                bcd     <= bus.hex_mode ? value_ext[BW-1:0] : '0;
                ovf_acc <= bus.hex_mode ? |(value_ext >> BW) : 1'b0;
            end else if (state == IDLE && start) begin
                start <= 1'b0;
            end
            if (state == CONV) begin
                bcd <= {bcd_adj[BW-2:0], mag[WIDTH-1]};
                mag <= mag << 1;
                cnt <= cnt + 1'b1;
                if (bcd_adj[BW-1]) ovf_acc <= 1'b1;
            end
            if (state == FINAL) begin
                num_q  <= f_num;
                dec_q  <= f_dec;
                sign_q <= f_sign;
                off_q  <= f_off;
                ovf_q  <= f_ovf;
                done_q <= 1'b1;
            end
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.ovf      = ovf_q;
    assign bus.dig_num  = num_q;
    assign bus.dig_dec  = dec_q;
    assign bus.dig_sign = sign_q;
    assign bus.dig_off  = off_q;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench: one stimulus stream drives a 6-digit and a 4-digit instance, each with its own expected queue.
module tb_hex_display_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hex_display_ctrl_if #(.DIGITS(6), .WIDTH(16)) bus ();
    hex_display_ctrl_if #(.DIGITS(4), .WIDTH(16)) if4 ();

    assign if4.load        = bus.load;
    assign if4.value       = bus.value;
    assign if4.signed_mode = bus.signed_mode;
    assign if4.hex_mode    = bus.hex_mode;
    assign if4.dp_sel      = bus.dp_sel[3:0];

    hex_display_ctrl #(.DIGITS(6), .WIDTH(16)) dut6 (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
    hex_display_ctrl #(.DIGITS(4), .WIDTH(16)) dut4 (.clk(clk), .reset_n(reset_n), .bus(if4.slave));

    typedef struct {
        logic [23:0] num;
        logic [5:0]  dec;
        logic [5:0]  sign;
        logic [5:0]  off;
        logic        ovf;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [15:0] v;
        bit          sg;
        bit          hx;
        logic [5:0]  dp;
    } stim_t;

    exp_t q6[$];
    exp_t q4[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: digits by integer division, independent of the shift-and-add datapath.
    function automatic exp_t model(input int nd, input logic [15:0] v, input bit sg,
                                   input bit hx, input logic [5:0] dp);
        exp_t       e;
        int         m, p, top;
        int         d[6];
        bit         neg, ov;
        logic [5:0] dpm;
        neg = !hx && sg && v[15];
        m   = neg ? (65536 - int'(v)) : int'(v);
        dpm = dp & 6'((1 << nd) - 1);
        p   = 1;
        for (int i = 0; i < 6; i++) d[i] = 0;
        for (int i = 0; i < nd; i++) begin
            d[i] = hx ? ((m >> (4*i)) & 15) : ((m / p) % 10);
            p = p * 10;
        end
        ov  = hx ? ((m >> (4*nd)) != 0) : (m >= p);
        top = 0;
        for (int i = 0; i < nd; i++) if (d[i] != 0 || dpm[i]) top = i;
        if (neg && top == nd - 1) ov = 1'b1;
        e.num = '0; e.dec = '0; e.sign = '0; e.off = '0; e.ovf = ov; e.cyc = 0;
        if (ov) begin
            for (int i = 0; i < nd; i++) e.sign[i] = 1'b1;
        end else begin
            e.dec = dpm;
            for (int i = 0; i < nd; i++) begin
                if (i <= top)                   e.num[4*i +: 4] = 4'(d[i]);
                else if (neg && i == top + 1)   e.sign[i] = 1'b1;
                else                            e.off[i] = 1'b1;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset_n && bus.done) begin
            if (q6.size() == 0) chk("dut6_unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q6.pop_front();
                chk("dut6_num",  32'(bus.dig_num),  32'(e.num));
                chk("dut6_dec",  32'(bus.dig_dec),  32'(e.dec));
                chk("dut6_sign", 32'(bus.dig_sign), 32'(e.sign));
                chk("dut6_off",  32'(bus.dig_off),  32'(e.off));
                chk("dut6_ovf",  32'(bus.ovf),      32'(e.ovf));
                chk("dut6_done_cycle", 32'(cyc),    32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && if4.done) begin
            if (q4.size() == 0) chk("dut4_unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q4.pop_front();
                chk("dut4_num",  32'(if4.dig_num),  32'(e.num));
                chk("dut4_dec",  32'(if4.dig_dec),  32'(e.dec));
                chk("dut4_sign", 32'(if4.dig_sign), 32'(e.sign));
                chk("dut4_off",  32'(if4.dig_off),  32'(e.off));
                chk("dut4_ovf",  32'(if4.ovf),      32'(e.ovf));
                chk("dut4_done_cycle", 32'(cyc),    32'(e.cyc));
            end
        end
    end

    // Called at a negedge; returns just after the accepting edge with k = that edge's cycle number.
    task automatic do_load(input stim_t s, input bit push, output int k);
        exp_t e;
        bus.load        = 1'b1;
        bus.value       = s.v;
        bus.signed_mode = s.sg;
        bus.hex_mode    = s.hx;
        bus.dp_sel      = s.dp;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        k = cyc;
        if (push) begin
            e = model(6, s.v, s.sg, s.hx, s.dp);
            e.cyc = k + (s.hx ? 2 : 18);
            q6.push_back(e);
            e = model(4, s.v, s.sg, s.hx, s.dp);
            e.cyc = k + (s.hx ? 2 : 18);
            q4.push_back(e);
        end
    endtask

    // Returns at the negedge where DONE is seen, so the next load lands in the DONE cycle.
    task automatic wait_done(input int k);
        int busy_bad = 0;
        bit seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else if (cyc >= k + 1 && !bus.busy) busy_bad++;
        end
        chk("done_seen", 32'(seen), 1);
        chk("busy_while_converting", 32'(busy_bad), 0);
        chk("busy_low_at_done", 32'(bus.busy), 0);
        if (!seen) begin
            q6.delete();
            q4.delete();
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_off6",  32'(bus.dig_off), 32'h3F);
        chk("rst_num6",  32'(bus.dig_num), 0);
        chk("rst_sign6", 32'(bus.dig_sign), 0);
        chk("rst_dec6",  32'(bus.dig_dec), 0);
        chk("rst_busy6", 32'(bus.busy), 0);
        chk("rst_done6", 32'(bus.done), 0);
        chk("rst_ovf6",  32'(bus.ovf), 0);
        chk("rst_off4",  32'(if4.dig_off), 32'hF);
        chk("rst_busy4", 32'(if4.busy), 0);
    endtask

    stim_t tbl[] = '{
        '{16'd1234,  1'b0, 1'b0, 6'b000000},
        '{16'hFF85,  1'b1, 1'b0, 6'b000000},
        '{16'h8000,  1'b1, 1'b0, 6'b000000},
        '{16'd12345, 1'b0, 1'b0, 6'b000000},
        '{16'h00A5,  1'b0, 1'b1, 6'b000000},
        '{16'h0005,  1'b0, 1'b1, 6'b000100},
        '{16'd0,     1'b0, 1'b0, 6'b000000},
        '{16'd0,     1'b0, 1'b0, 6'b100000},
        '{16'hFFFF,  1'b0, 1'b0, 6'b000000},
        '{16'hFC18,  1'b1, 1'b0, 6'b000000},
        '{16'hFC19,  1'b1, 1'b0, 6'b000000},
        '{16'd100,   1'b1, 1'b0, 6'b001000},
        '{16'hFFFF,  1'b1, 1'b1, 6'b000000},
        '{16'hCFC7,  1'b1, 1'b0, 6'b000010},
        '{16'hFFFF,  1'b1, 1'b0, 6'b000001},
        '{16'd9999,  1'b0, 1'b0, 6'b000000}
    };

    initial begin
        int k;
        int extra;
        bus.load = 1'b0; bus.value = '0; bus.signed_mode = 1'b0; bus.hex_mode = 1'b0; bus.dp_sel = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        reset_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            do_load(tbl[i], 1'b1, k);
            wait_done(k);
        end

        // A LOAD pulse mid-conversion must not start a second conversion.
        do_load(tbl[0], 1'b1, k);
        repeat (5) @(negedge clk);
        bus.load = 1'b1; bus.value = 16'd777;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        wait_done(k);
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done || if4.done) extra++;
        end
        chk("busy_load_ignored", 32'(extra), 0);

        // Reset in the middle of a conversion aborts it without a DONE.
        do_load(tbl[1], 1'b0, k);
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset_state();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done || if4.done || bus.busy) extra++;
        end
        chk("abort_no_done", 32'(extra), 0);

        do_load(tbl[2], 1'b1, k);
        wait_done(k);
        repeat (3) @(negedge clk);
        chk("q6_drained", 32'(q6.size()), 0);
        chk("q4_drained", 32'(q4.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
